// File: rtl/gauss_filter_if.sv
// Bus bundle for the Gaussian pulse-shaping FIR: tap load port, input sample
// stream and filtered output stream. clk/rst are plain module ports.
interface gauss_filter_if #(
    parameter int W   = 16,
    parameter int TIW = 4
);
    // Streams are one-cycle valid strobes with no ready: a sample is taken on
    // every clock edge that sees valid high, and last is only meaningful with valid.
    logic [TIW-1:0]      tap_index;
    logic signed [W-1:0] tap_value;
    logic                bit_upsample;
    logic                bit_upsample_valid;
    logic                bit_upsample_valid_last;
    logic signed [W-1:0] bit_upsample_gauss_filter;
    logic                bit_upsample_gauss_filter_valid;
    logic                bit_upsample_gauss_filter_valid_last;

    modport master (
        output tap_index, tap_value,
        output bit_upsample, bit_upsample_valid, bit_upsample_valid_last,
        input  bit_upsample_gauss_filter, bit_upsample_gauss_filter_valid,
        input  bit_upsample_gauss_filter_valid_last
    );

    modport slave (
        input  tap_index, tap_value,
        input  bit_upsample, bit_upsample_valid, bit_upsample_valid_last,
        output bit_upsample_gauss_filter, bit_upsample_gauss_filter_valid,
        output bit_upsample_gauss_filter_valid_last
    );
endinterface

// File: rtl/gauss_filter.sv
// Symmetric Gaussian FIR for the GFSK transmitter: NRZ bits map to +/-1,
// convolve with a run-time loaded half kernel, saturate, two-stage pipeline.
module gauss_filter #(
    parameter int GAUSS_FILTER_BIT_WIDTH = 16,
    parameter int NUM_TAP_GAUSS_FILTER   = 17
) (
    input logic           clk,
    input logic           rst,
    gauss_filter_if.slave bus
);
    localparam int W   = GAUSS_FILTER_BIT_WIDTH;
    localparam int N   = NUM_TAP_GAUSS_FILTER;
    localparam int U   = (N + 1) / 2;
    localparam int AW  = W + $clog2(N) + 1;
    localparam int TIW = 4;

    localparam logic signed [AW-1:0] SAT_MAX = (AW'(1) <<< (W - 1)) - AW'(1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [W-1:0]  r_tap [U];
    logic signed [1:0]    r_x   [N];
    logic                 r_s1_valid;
    logic                 r_s1_last;
    logic signed [W-1:0]  r_out;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic signed [AW-1:0] w_acc;
    logic signed [W-1:0]  w_sat;

    // Taps are written every edge; addresses past the half kernel fall through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < U; i++) r_tap[i] <= '0;
        end else begin
            for (int i = 0; i < U; i++) begin
                if (bus.tap_index == TIW'(i)) r_tap[i] <= bus.tap_value;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) r_x[k] <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= bus.bit_upsample_valid;
            r_s1_last  <= bus.bit_upsample_valid & bus.bit_upsample_valid_last;
            if (bus.bit_upsample_valid) begin
                r_x[0] <= bus.bit_upsample ? 2'sb01 : 2'sb11;
                for (int k = 1; k < N; k++) r_x[k] <= r_x[k-1];
            end
        end
    end

    // Each delay entry is -1/0/+1, so every product is a subtract, skip or add.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < N; k++) begin
            case (r_x[k])
                2'sb01:  w_acc = w_acc + AW'(r_tap[(k < U) ? k : N - 1 - k]);
                2'sb11:  w_acc = w_acc - AW'(r_tap[(k < U) ? k : N - 1 - k]);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_sat = w_acc[W-1:0];
        if (w_acc > SAT_MAX)      w_sat = SAT_MAX[W-1:0];
        else if (w_acc < SAT_MIN) w_sat = SAT_MIN[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_valid & r_s1_last;
            if (r_s1_valid) r_out <= w_sat;
        end
    end

    assign bus.bit_upsample_gauss_filter            = r_out;
    assign bus.bit_upsample_gauss_filter_valid      = r_out_valid;
    assign bus.bit_upsample_gauss_filter_valid_last = r_out_last;
endmodule

// File: tb/tb_gauss_filter.sv
// Bench for gauss_filter: table-driven ramp with hand-derived outputs plus
// model-backed streams, checked through an expected-output queue.
module tb_gauss_filter;
    localparam int W = 16;
    localparam int N = 17;
    localparam int U = 9;

    typedef struct {
        logic                b;
        logic                last;
        logic signed [W-1:0] exp;
    } vec_t;

    localparam int RAMP_EXP [20] = '{1, 3, 7, 15, 31, 63, 127, 255, 511, 639,
                                     703, 735, 751, 759, 763, 765, 766, 766, 766, 766};

    logic clk;
    logic rst;

    gauss_filter_if #(.W(W), .TIW(4)) bus ();

    gauss_filter #(
        .GAUSS_FILTER_BIT_WIDTH(W),
        .NUM_TAP_GAUSS_FILTER  (N)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_last   = 0;
    int run_len  = 0;
    int max_run  = 0;
    logic [W:0]          exp_q [$];
    logic [W:0]          mon_e;
    logic signed [W-1:0] hold_exp = '0;

    int m_tap [U];
    int m_x   [N];
    vec_t ramp_tbl [20];

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_exp = '0;
            run_len  = 0;
        end else if (bus.bit_upsample_gauss_filter_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (bus.bit_upsample_gauss_filter_valid_last) n_last++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output got=%0d expected=none",
                         $signed(bus.bit_upsample_gauss_filter));
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", $signed(bus.bit_upsample_gauss_filter), $signed(mon_e[W-1:0]));
                check("out_last", longint'(bus.bit_upsample_gauss_filter_valid_last), longint'(mon_e[W]));
                hold_exp = mon_e[W-1:0];
            end
        end else begin
            run_len = 0;
            check("hold_data", $signed(bus.bit_upsample_gauss_filter), hold_exp);
            check("idle_last", longint'(bus.bit_upsample_gauss_filter_valid_last), 0);
        end
    end

    function automatic int model_y();
        int acc = 0;
        for (int k = 0; k < N; k++) acc += m_x[k] * m_tap[(k < U) ? k : N - 1 - k];
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < U; i++) m_tap[i] = 0;
        for (int k = 0; k < N; k++) m_x[k] = 0;
    endtask

    // Called right after a negedge; returns on a negedge.
    task automatic drive_sample(input logic b, input logic last, input int gap,
                                input logic use_tbl, input logic signed [W-1:0] tbl_exp);
        int y;
        bus.bit_upsample            = b;
        bus.bit_upsample_valid      = 1'b1;
        bus.bit_upsample_valid_last = last;
        for (int k = N - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = b ? 1 : -1;
        y = model_y();
        exp_q.push_back({last, use_tbl ? tbl_exp : W'(y)});
        @(negedge clk);
        bus.bit_upsample_valid      = 1'b0;
        bus.bit_upsample_valid_last = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic load_taps(input int v [U]);
        for (int i = 0; i < U; i++) begin
            bus.tap_index = 4'(i);
            bus.tap_value = W'(v[i]);
            @(negedge clk);
            m_tap[i] = v[i];
        end
        bus.tap_index = 4'd15;
        bus.tap_value = 16'h7abc;
    endtask

    task automatic drain();
        int budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout got=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int taps_a [U];
        int taps_s [U];
        int taps_r [U];
        int lasts0;

        rst                         = 1'b1;
        bus.tap_index               = 4'd15;
        bus.tap_value               = 16'h7abc;
        bus.bit_upsample            = 1'b0;
        bus.bit_upsample_valid      = 1'b0;
        bus.bit_upsample_valid_last = 1'b0;
        model_reset();
        for (int i = 0; i < U; i++) begin
            taps_a[i] = 1 << i;
            taps_s[i] = 4000;
        end
        for (int i = 0; i < 20; i++) begin
            ramp_tbl[i].b    = 1'b1;
            ramp_tbl[i].last = (i == 19);
            ramp_tbl[i].exp  = W'(RAMP_EXP[i]);
        end

        repeat (3) @(negedge clk);
        check("rst_data",  $signed(bus.bit_upsample_gauss_filter), 0);
        check("rst_valid", longint'(bus.bit_upsample_gauss_filter_valid), 0);
        check("rst_last",  longint'(bus.bit_upsample_gauss_filter_valid_last), 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp of ones, every second cycle; the first sample also pins latency.
        load_taps(taps_a);
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                drive_sample(ramp_tbl[i].b, ramp_tbl[i].last, 0, 1'b1, ramp_tbl[i].exp);
                check("lat_edge0_valid", longint'(bus.bit_upsample_gauss_filter_valid), 0);
                @(negedge clk);
                check("lat_edge1_valid", longint'(bus.bit_upsample_gauss_filter_valid), 1);
                @(negedge clk);
                check("lat_edge2_valid", longint'(bus.bit_upsample_gauss_filter_valid), 0);
            end else begin
                drive_sample(ramp_tbl[i].b, ramp_tbl[i].last, 1, 1'b1, ramp_tbl[i].exp);
            end
        end
        drain();

        for (int i = 0; i < 20; i++) drive_sample(1'b0, 1'b0, 1, 1'b0, '0);
        drain();
        check("steady_neg", $signed(bus.bit_upsample_gauss_filter), -766);

        for (int i = 0; i < 20; i++) drive_sample(1'(i % 2 == 0), 1'b0, 0, 1'b0, '0);
        drain();
        check("alt_steady", $signed(bus.bit_upsample_gauss_filter), -86);

        load_taps(taps_s);
        for (int i = 0; i < 20; i++) drive_sample(1'b1, 1'b0, 0, 1'b0, '0);
        drain();
        check("sat_pos", $signed(bus.bit_upsample_gauss_filter), 32767);
        for (int i = 0; i < 20; i++) drive_sample(1'b0, 1'b0, 0, 1'b0, '0);
        drain();
        check("sat_neg", $signed(bus.bit_upsample_gauss_filter), -32768);

        // Thirty back-to-back samples, last on the final one.
        for (int i = 0; i < U; i++) taps_r[i] = int'($urandom_range(0, 4000)) - 2000;
        load_taps(taps_r);
        max_run = 0;
        lasts0  = n_last;
        for (int i = 0; i < 30; i++) drive_sample(1'($urandom_range(0, 1)), 1'(i == 29), 0, 1'b0, '0);
        drain();
        check("b2b_run", max_run, 30);
        check("b2b_lasts", n_last - lasts0, 1);

        // Reset while a sample is in flight.
        load_taps(taps_a);
        for (int i = 0; i < 6; i++) drive_sample(1'b1, 1'(i == 5), 0, 1'b0, '0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        hold_exp = '0;
        model_reset();
        #1;
        check("midrst_data",  $signed(bus.bit_upsample_gauss_filter), 0);
        check("midrst_valid", longint'(bus.bit_upsample_gauss_filter_valid), 0);
        check("midrst_last",  longint'(bus.bit_upsample_gauss_filter_valid_last), 0);
        lasts0 = n_last;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_dropped_last", n_last - lasts0, 0);
        for (int i = 0; i < 3; i++) drive_sample(1'(i % 2), 1'b0, 1, 1'b0, '0);
        drain();
        check("zero_taps_out", $signed(bus.bit_upsample_gauss_filter), 0);
        load_taps(taps_a);
        for (int i = 0; i < 10; i++) drive_sample(1'b1, 1'b0, 1, 1'b0, '0);
        drain();

        // Sparse random stream with random signed taps.
        load_taps(taps_r);
        for (int i = 0; i < 40; i++)
            drive_sample(1'($urandom_range(0, 1)), 1'(i == 39), $urandom_range(0, 2), 1'b0, '0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
